display_scan_driver: RTL and testbench
======================================

// Module: display_scan_driver
// PURPOSE
//   Downstream consumer of the 3-bit digit-scan counter. Turns the current digit index into
//   active-low anode and segment drive for the Nexys A7 8-digit 7-segment display.
//   Holds frame-consistent display data: updates apply only at the start of a scan frame.
//   Inserts an anti-ghosting blank interval on every digit change.
// PARAMETERS
//   N_DIGITS      8   digits scanned; fixed at 8 to match the 3-bit index
//   BLANK_CYCLES  4   clk cycles all anodes are held off after each digit change; legal 1..255
// PORTS
//   clk          in   1        system clock; single clock domain
//   reset        in   1        synchronous, active-high reset
//   digit_sel    in   3        current digit index from the scan counter
//   data_in      in   32       8 hex nibbles; nibble k (bits 4k+3:4k) shows on digit k
//   dp_in        in   8        decimal point request per digit, 1 = lit
//   digit_en     in   8        per-digit enable, 0 = digit kept dark
//   load         in   1        1-cycle strobe: capture data_in/dp_in/digit_en as pending
//   an           out  8        anode drive, active-low, at most one bit low
//   seg          out  7        segments {CG..CA}, active-low
//   dp           out  1        decimal point, active-low
//   frame_start  out  1        1-cycle pulse when pending data is committed at frame start
//   update_pend  out  1        1 while a loaded update waits for the next frame start
// BEHAVIOUR
//   All outputs are registered. Reset values: an=8'hFF, seg=7'h7F, dp=1, frame_start=0,
//     update_pend=0, shadow data/dp/en=0, sel_q=0, state=BLANK, blank count=BLANK_CYCLES.
//   Change detect: sel_q registers digit_sel each cycle. chg = (digit_sel != sel_q).
//   FSM with two states:
//     BLANK: an=8'hFF, seg=7'h7F, dp=1. The counter decrements each cycle.
//            At count==1, go to DRIVE on the next cycle.
//            If chg occurs, reload count=BLANK_CYCLES and stay in BLANK.
//     DRIVE: an[sel_q]=0 only if shadow_en[sel_q]=1, otherwise an=8'hFF.
//            seg = hex7seg(shadow nibble sel_q); dp = ~shadow_dp[sel_q].
//            If chg occurs, go to BLANK with count=BLANK_CYCLES.
//   Timing: digit_sel changes at cycle n, so chg is seen at n+1. an is blank from n+2
//     for exactly BLANK_CYCLES cycles. The new digit is driven from n+2+BLANK_CYCLES.
//   Pending buffer: load=1 captures data_in, dp_in and digit_en into pending and sets
//     update_pend=1. A later load before commit overwrites pending (last one wins).
//   Commit happens on a frame boundary: chg=1 with digit_sel==0.
//     If update_pend=1, or load=1 in the same cycle, copy into shadow, clear update_pend,
//       and pulse frame_start=1 on the next cycle.
//     When load and commit coincide, the data loaded in that cycle is committed directly.
//     If neither condition holds, shadow is kept and frame_start stays 0.
//   The shadow never changes mid-frame. Digits 1..7 of a frame always show one data set.
//   Wrap from 7 to 0 is the only frame boundary. Any other jump (e.g. 3 to 0) counts as a
//     boundary when the new index is 0; non-sequential indices are otherwise legal.
//   Reset mid-operation: all state returns to reset values in the next cycle and the
//     pending update is discarded. Display is dark until BLANK_CYCLES cycles after reset
//     deasserts, then digit_sel's digit is driven, using the all-zero shadow (all digits off).
//   hex7seg: 0-F map to the standard active-low patterns, e.g. 0 -> 7'b1000000,
//     8 -> 7'b0000000, F -> 7'b0001110.
// STRUCTURE
//   Package display_pkg holds:
//     typedef enum logic {BLANK, DRIVE} scan_state_t;
//     localparam logic [6:0] SEG_LUT[16] (active-low hex patterns);
//     localparam SEG_OFF = 7'h7F and AN_OFF = 8'hFF.
//   Sub-module hex_to_7seg: combinational 4-bit to 7-bit lookup into SEG_LUT.
//   Top level holds sel_q, the FSM, the blank counter, the pending/shadow registers and
//     the output registers.
// TESTING
//   1. Reset: reset held 3 cycles, then released -> an=FF, seg=7F, dp=1 until
//      BLANK_CYCLES cycles after release; frame_start never pulses.
//   2. Blanking: digit_sel steps 0->1 with shadow nibble1=4'h5 and en=FF -> an=FF for
//      exactly 4 cycles, then an=8'hFD, seg=7'b0010010.
//   3. Frame commit: load data_in=32'h76543210 while digit_sel=3 -> update_pend=1, shadow
//      unchanged through digit 7; on the 7->0 wrap frame_start pulses once, update_pend=0,
//      and digit 0 shows seg=7'b1000000.
//   4. Coincident events: load=1 in the same cycle as the 7->0 change -> that data is
//      committed and frame_start=1. A second load (last wins) before the wrap -> only the
//      second value is displayed.
//   5. Mask/dp: digit_en=8'b11111011, dp_in=8'h04 -> digit 2 keeps an=FF; dp_in=8'h01 ->
//      dp=0 only while digit 0 is driven.
//   6. Glitch: digit_sel changes 1->2->3 on consecutive cycles -> blank count restarts;
//      an=FF until 4 cycles after the last change; no anode is ever low during BLANK.

Source files
------------

// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Package     : display_pkg
// Description : Shared types and constants for the 7-segment scan driver.
// Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

  // Two-state scan FSM: all anodes dark, or one digit driven.
  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // Active-low segment patterns {CG,CF,CE,CD,CC,CB,CA} for hex digits 0..F.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

endpackage : display_pkg
`default_nettype wire

// File: rtl/hex_to_7seg.sv
`default_nettype none
// ============================================================================
// Module      : hex_to_7seg
// Description : Combinational hex nibble to active-low 7-segment pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_LUT[i_nibble];

endmodule : hex_to_7seg
`default_nettype wire

// File: rtl/display_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_driver
// Description : Converts the scan counter's digit index into active-low anode
//               and segment drive. Display data is double-buffered so that a
//               whole frame shows one data set, and every digit change is
//               followed by a short all-dark interval to suppress ghosting.
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan_driver
  import display_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              digit_sel,
  input  logic [4*N_DIGITS-1:0]   data_in,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic [N_DIGITS-1:0]     digit_en,
  input  logic                    load,
  output logic [N_DIGITS-1:0]     an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_start,
  output logic                    update_pend
);

  localparam logic [7:0] C_BLANK_LOAD = 8'(BLANK_CYCLES);

  // Scan tracking
  logic [2:0]              r_sel_q;
  logic                    w_chg;
  logic                    w_commit;

  // FSM and blank counter
  scan_state_t             r_state;
  scan_state_t             w_state_nxt;
  logic [7:0]              r_blank_cnt;
  logic [7:0]              w_blank_cnt_nxt;

  // Pending (loaded) and shadow (displayed) data sets
  logic [4*N_DIGITS-1:0]   r_pend_data;
  logic [N_DIGITS-1:0]     r_pend_dp;
  logic [N_DIGITS-1:0]     r_pend_en;
  logic                    r_update_pend;
  logic [4*N_DIGITS-1:0]   r_shadow_data;
  logic [N_DIGITS-1:0]     r_shadow_dp;
  logic [N_DIGITS-1:0]     r_shadow_en;

  // Output path
  logic [3:0]              w_nibble;
  logic [6:0]              w_seg_dec;
  logic [N_DIGITS-1:0]     w_an;
  logic [6:0]              w_seg;
  logic                    w_dp;
  logic [N_DIGITS-1:0]     r_an;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic                    r_frame_start;

  // A frame boundary is any change that lands on digit 0; commit only if
  // there is something to commit (held pending data or a same-cycle load).
  assign w_chg    = (digit_sel != r_sel_q);
  assign w_commit = w_chg && (digit_sel == 3'd0) && (r_update_pend || load);

  assign w_nibble = r_shadow_data[{r_sel_q, 2'b00} +: 4];

  hex_to_7seg u_hex_to_7seg (
    .i_nibble (w_nibble),
    .o_seg    (w_seg_dec)
  );

  // Track the previous digit index to detect changes.
  always_ff @(posedge clk) begin
    if (reset) r_sel_q <= 3'd0;
    else       r_sel_q <= digit_sel;
  end

  // FSM state and blank counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= BLANK;
      r_blank_cnt <= C_BLANK_LOAD;
    end else begin
      r_state     <= w_state_nxt;
      r_blank_cnt <= w_blank_cnt_nxt;
    end
  end

  // Next-state logic and the drive pattern for the current state.
  always_comb begin
    w_state_nxt     = r_state;
    w_blank_cnt_nxt = r_blank_cnt;
    w_an            = AN_OFF;
    w_seg           = SEG_OFF;
    w_dp            = 1'b1;
    case (r_state)
      BLANK: begin
        if (w_chg) begin
          w_blank_cnt_nxt = C_BLANK_LOAD;
        end else begin
          w_blank_cnt_nxt = r_blank_cnt - 8'd1;
          if (r_blank_cnt == 8'd1) w_state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        // Outputs still show the old digit in this cycle since r_sel_q has
        // not yet advanced; the blank interval covers the switch-over.
        if (r_shadow_en[r_sel_q]) w_an[r_sel_q] = 1'b0;
        w_seg = w_seg_dec;
        w_dp  = ~r_shadow_dp[r_sel_q];
        if (w_chg) begin
          w_state_nxt     = BLANK;
          w_blank_cnt_nxt = C_BLANK_LOAD;
        end
      end
      default: begin
        w_state_nxt     = BLANK;
        w_blank_cnt_nxt = C_BLANK_LOAD;
      end
    endcase
  end

  // Pending capture and frame-boundary commit into the shadow set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_data   <= '0;
      r_pend_dp     <= '0;
      r_pend_en     <= '0;
      r_update_pend <= 1'b0;
      r_shadow_data <= '0;
      r_shadow_dp   <= '0;
      r_shadow_en   <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_commit;
      if (w_commit) begin
        // A load in the commit cycle bypasses the pending buffer.
        if (load) begin
          r_shadow_data <= data_in;
          r_shadow_dp   <= dp_in;
          r_shadow_en   <= digit_en;
        end else begin
          r_shadow_data <= r_pend_data;
          r_shadow_dp   <= r_pend_dp;
          r_shadow_en   <= r_pend_en;
        end
        r_update_pend <= 1'b0;
      end else if (load) begin
        r_pend_data   <= data_in;
        r_pend_dp     <= dp_in;
        r_pend_en     <= digit_en;
        r_update_pend <= 1'b1;
      end
    end
  end

  // Register the display drive.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an;
      r_seg <= w_seg;
      r_dp  <= w_dp;
    end
  end

  assign an          = r_an;
  assign seg         = r_seg;
  assign dp          = r_dp;
  assign frame_start = r_frame_start;
  assign update_pend = r_update_pend;

endmodule : display_scan_driver
`default_nettype wire

// File: tb/tb_display_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scan_driver
// Description : Directed self-checking bench for display_scan_driver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scan_driver;

  localparam int B = 4;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  digit_sel;
  logic [31:0] data_in;
  logic [7:0]  dp_in;
  logic [7:0]  digit_en;
  logic        load;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;
  logic        update_pend;

  int    n_tests = 0;
  int    n_fail  = 0;
  exp_t  exp_q[$];
  string tag_q[$];
  exp_t  cur;

  always #5 clk = ~clk;

  display_scan_driver #(.N_DIGITS(8), .BLANK_CYCLES(B)) dut (
    .clk         (clk),
    .reset       (reset),
    .digit_sel   (digit_sel),
    .data_in     (data_in),
    .dp_in       (dp_in),
    .digit_en    (digit_en),
    .load        (load),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start),
    .update_pend (update_pend)
  );

  function automatic logic [6:0] ref_seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic exp_t mk(input logic [7:0] a, input logic [6:0] s,
                              input logic d, input logic f);
    exp_t e;
    e.an = a; e.seg = s; e.dp = d; e.fs = f;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input exp_t e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic pop_check();
    exp_t  e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    n_tests++;
    assert ({an, seg, dp, frame_start} === e) else begin
      n_fail++;
      $error("FAIL %s: got an=%h seg=%b dp=%b fs=%b, want an=%h seg=%b dp=%b fs=%b",
             t, an, seg, dp, frame_start, e.an, e.seg, e.dp, e.fs);
    end
  endtask

  task automatic drain();
    while (exp_q.size() > 0) begin
      tick();
      pop_check();
    end
  endtask

  task automatic check_up(input string tag, input logic want);
    n_tests++;
    assert (update_pend === want) else begin
      n_fail++;
      $error("FAIL %s: got update_pend=%b, want %b", tag, update_pend, want);
    end
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] p, input logic [7:0] e);
    data_in  = d;
    dp_in    = p;
    digit_en = e;
    load     = 1'b1;
    tick();
    load     = 1'b0;
  endtask

  // Move to a new digit: old digit for one cycle, B dark cycles, then new.
  task automatic move(input string tag, input logic [2:0] sel, input logic [7:0] ean,
                      input logic [6:0] eseg, input logic edp, input logic efs);
    exp_t nw;
    nw = mk(ean, eseg, edp, 1'b0);
    digit_sel = sel;
    push({tag, "_old"}, mk(cur.an, cur.seg, cur.dp, efs));
    for (int i = 0; i < B; i++) push({tag, "_blank"}, mk(8'hFF, 7'h7F, 1'b1, 1'b0));
    push({tag, "_new"}, nw);
    tick();
    pop_check();
    load = 1'b0;
    drain();
    cur = nw;
  endtask

  task automatic reset_release(input string tag);
    reset = 1'b0;
    for (int i = 0; i < B; i++) push({tag, "_dark"}, mk(8'hFF, 7'h7F, 1'b1, 1'b0));
    push({tag, "_first"}, mk(8'hFF, ref_seg(4'h0), 1'b1, 1'b0));
    drain();
    cur = mk(8'hFF, ref_seg(4'h0), 1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b1; digit_sel = 3'd0; data_in = '0; dp_in = '0; digit_en = '0; load = 1'b0;
    cur = mk(8'hFF, 7'h7F, 1'b1, 1'b0);

    // 1. Reset held 3 cycles, then released
    tick(); tick(); tick();
    push("reset_state", mk(8'hFF, 7'h7F, 1'b1, 1'b0));
    pop_check();
    check_up("reset_up", 1'b0);
    reset_release("rst1");

    // Seed shadow: nibble1 = 5, all enabled
    do_load(32'h0000_0050, 8'h00, 8'hFF);
    check_up("seed_up", 1'b1);
    move("seed7", 3'd7, 8'hFF, ref_seg(4'h0), 1'b1, 1'b0);
    move("seed0", 3'd0, 8'hFE, ref_seg(4'h0), 1'b1, 1'b1);
    check_up("seed_up_clr", 1'b0);

    // 2. Blanking 0->1
    move("blank01", 3'd1, 8'hFD, 7'b0010010, 1'b1, 1'b0);

    // 3. Frame commit held until wrap
    move("f3", 3'd3, 8'hF7, ref_seg(4'h0), 1'b1, 1'b0);
    do_load(32'h7654_3210, 8'h00, 8'hFF);
    check_up("f3_up", 1'b1);
    move("f7_old_data", 3'd7, 8'h7F, ref_seg(4'h0), 1'b1, 1'b0);
    check_up("f7_up", 1'b1);
    move("wrap0", 3'd0, 8'hFE, 7'b1000000, 1'b1, 1'b1);
    check_up("wrap0_up", 1'b0);
    move("f5_new_data", 3'd5, 8'hDF, ref_seg(4'h5), 1'b1, 1'b0);

    // 4. Coincident load and wrap, then last-load-wins
    move("c7", 3'd7, 8'h7F, ref_seg(4'h7), 1'b1, 1'b0);
    data_in = 32'h89AB_CDEF; dp_in = 8'h00; digit_en = 8'hFF; load = 1'b1;
    move("coinc0", 3'd0, 8'hFE, ref_seg(4'hF), 1'b1, 1'b1);
    check_up("coinc_up", 1'b0);
    move("c3", 3'd3, 8'hF7, ref_seg(4'hC), 1'b1, 1'b0);
    do_load(32'h1111_1111, 8'h00, 8'hFF);
    move("c4", 3'd4, 8'hEF, ref_seg(4'hB), 1'b1, 1'b0);
    do_load(32'h2222_2222, 8'h00, 8'hFF);
    check_up("c4_up", 1'b1);
    move("c7b", 3'd7, 8'h7F, ref_seg(4'h8), 1'b1, 1'b0);
    move("last0", 3'd0, 8'hFE, ref_seg(4'h2), 1'b1, 1'b1);
    move("last1", 3'd1, 8'hFD, ref_seg(4'h2), 1'b1, 1'b0);

    // 5. Enable mask and decimal point
    do_load(32'h7654_3210, 8'h04, 8'b1111_1011);
    move("m7", 3'd7, 8'h7F, ref_seg(4'h2), 1'b1, 1'b0);
    move("m0", 3'd0, 8'hFE, ref_seg(4'h0), 1'b1, 1'b1);
    move("mask2", 3'd2, 8'hFF, ref_seg(4'h2), 1'b0, 1'b0);
    do_load(32'h7654_3210, 8'h01, 8'hFF);
    move("d7", 3'd7, 8'h7F, ref_seg(4'h7), 1'b1, 1'b0);
    move("dp0", 3'd0, 8'hFE, ref_seg(4'h0), 1'b0, 1'b1);
    move("dp1", 3'd1, 8'hFD, ref_seg(4'h1), 1'b1, 1'b0);

    // 6. Glitch 1->2->3 on consecutive cycles restarts blanking
    push("glitch_old", cur);
    digit_sel = 3'd2;
    tick(); pop_check();
    digit_sel = 3'd3;
    for (int i = 0; i < B + 1; i++) push("glitch_blank", mk(8'hFF, 7'h7F, 1'b1, 1'b0));
    push("glitch_new", mk(8'hF7, ref_seg(4'h3), 1'b1, 1'b0));
    drain();
    cur = mk(8'hF7, ref_seg(4'h3), 1'b1, 1'b0);

    // Non-wrap jump 3->0 is also a frame boundary; a bare wrap commits nothing
    do_load(32'h0000_000A, 8'h00, 8'hFF);
    move("jump0", 3'd0, 8'hFE, ref_seg(4'hA), 1'b1, 1'b1);
    move("j7", 3'd7, 8'h7F, ref_seg(4'h0), 1'b1, 1'b0);
    move("bare0", 3'd0, 8'hFE, ref_seg(4'hA), 1'b1, 1'b0);

    // Reset mid-operation discards the pending update
    do_load(32'hFFFF_FFFF, 8'hFF, 8'hFF);
    check_up("mid_up", 1'b1);
    reset = 1'b1;
    push("mid_reset", mk(8'hFF, 7'h7F, 1'b1, 1'b0));
    tick(); pop_check();
    check_up("mid_reset_up", 1'b0);
    reset_release("rst2");
    check_up("rst2_up", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_display_scan_driver
`default_nettype wire
